// File: rtl/keypad_scanner.sv
// Purpose : scans a 4x4 active-low key matrix and emits debounced key events (5-bit digit codes).
// Latency : DEBOUNCE_FRAMES frames from stable press to key_valid, plus up to one frame of phase.
// Backpres: key_valid holds until key_ack; an event raised while still pending sets sticky overrun.
//
// Ports:
//   clk       system clock
//   reset     asynchronous active-low reset
//   rows      matrix rows, active low, asynchronous (synchronized internally)
//   cols      one-hot active-low column strobe
//   key_code  accepted key 5'h00..5'h0F, 5'h1F = none
//   key_valid event pending, cleared by key_ack
//   key_ack   consumer acknowledge
//   key_held  high while a debounced key is down
//   overrun   sticky, set when a pending event is overwritten
//
// Optional feature: define KEYPAD_REPEAT_EN for auto-repeat every REPEAT_FRAMES frames.
module keypad_scanner #(
  parameter int SCAN_DIV_W      = 17,
  parameter int DEBOUNCE_FRAMES = 4,
  parameter int REPEAT_FRAMES   = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [4:0] key_code,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       key_held,
  output logic       overrun
);

  localparam logic [4:0] NONE = 5'h1F;
  localparam logic [3:0] DEB  = 4'(DEBOUNCE_FRAMES);

  typedef enum logic {S_IDLE, S_PRESSED} state_t;

  logic [3:0]            rows_m, rows_s;
  logic [SCAN_DIV_W-1:0] div_q;
  logic [1:0]            col_idx;
  logic [4:0]            best_q, cand_q;
  logic [3:0]            cnt_q;
  state_t                state_q, state_nxt;

  logic       tick, frame_end, stable, evt, load_code, rep_fire;
  logic [4:0] col_res, acc, merged, code_nxt;
  logic [3:0] cnt_inc, cnt_nxt;

  // Two-flop synchronizer; idles at "no key pressed".
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rows_m <= 4'hF;
      rows_s <= 4'hF;
    end else begin
      rows_m <= rows;
      rows_s <= rows_m;
    end
  end

  assign tick      = &div_q;
  assign frame_end = tick && (col_idx == 2'd3);

  // Lowest pressed row in the active column; descending loop so the lowest row wins.
  always_comb begin
    col_res = NONE;
    for (int r = 3; r >= 0; r--) begin
      if (!rows_s[r]) col_res = {1'b0, 2'(r), col_idx};
    end
  end

  // Column 0 opens a new frame, so the running minimum restarts there.
  assign acc    = (col_idx == 2'd0) ? NONE : best_q;
  assign merged = (col_res < acc) ? col_res : acc;

  // Debounce: count saturates at DEB so a held result stays stable every frame.
  assign cnt_inc = (cnt_q >= DEB) ? cnt_q : cnt_q + 4'd1;
  assign cnt_nxt = (merged == cand_q) ? cnt_inc : 4'd1;
  assign stable  = frame_end && (cnt_nxt >= DEB);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q   <= '0;
      col_idx <= 2'd0;
      cols    <= 4'b1110;
      best_q  <= NONE;
      cand_q  <= NONE;
      cnt_q   <= 4'd0;
    end else begin
      div_q <= div_q + 1'b1;
      if (tick) begin
        col_idx <= col_idx + 2'd1;
        cols    <= {cols[2:0], cols[3]};
        best_q  <= merged;
      end
      if (frame_end) begin
        cand_q <= merged;
        cnt_q  <= cnt_nxt;
      end
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state_q;
    if (stable) begin
      case (state_q)
        S_IDLE:    if (merged != NONE) state_nxt = S_PRESSED;
        S_PRESSED: if (merged == NONE) state_nxt = S_IDLE;
        default:   state_nxt = S_IDLE;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    evt       = 1'b0;
    load_code = 1'b0;
    code_nxt  = key_code;
    if (stable) begin
      case (state_q)
        S_IDLE: begin
          if (merged != NONE) begin
            evt       = 1'b1;
            load_code = 1'b1;
            code_nxt  = merged;
          end
        end
        S_PRESSED: begin
          if (merged == NONE) begin
            load_code = 1'b1;
            code_nxt  = NONE;
          end else if (merged != key_code) begin
            evt       = 1'b1;
            load_code = 1'b1;
            code_nxt  = merged;
          end else begin
            evt = rep_fire;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_FRAMES + 1);
  logic [RW-1:0] rep_q;
  logic          same_key;

  // Frames since acceptance (or since the last repeat) with the same key held stable.
  assign same_key = stable && (state_q == S_PRESSED) && (merged == key_code);
  assign rep_fire = same_key && (rep_q == RW'(REPEAT_FRAMES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 rep_q <= '0;
    else if (load_code)         rep_q <= '0;
    else if (rep_fire)          rep_q <= '0;
    else if (same_key)          rep_q <= rep_q + 1'b1;
  end
`else
  assign rep_fire = 1'b0;
`endif

  // Handshake: a new event beats a same-cycle ack and only counts as overrun if unacked.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_code  <= NONE;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (load_code) key_code <= code_nxt;
      key_held <= (state_nxt == S_PRESSED);
      if (evt) begin
        key_valid <= 1'b1;
        if (key_valid && !key_ack) overrun <= 1'b1;
      end else if (key_ack) begin
        key_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;

  localparam int SDW = 4;
  localparam int DEB = 4;
  localparam int RPT = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  rows;
  logic [3:0]  cols;
  logic [4:0]  key_code;
  logic        key_valid;
  logic        key_ack = 1'b0;
  logic        key_held;
  logic        overrun;
  logic [15:0] mask = '0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  keypad_scanner #(
    .SCAN_DIV_W(SDW),
    .DEBOUNCE_FRAMES(DEB),
    .REPEAT_FRAMES(RPT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rows(rows),
    .cols(cols),
    .key_code(key_code),
    .key_valid(key_valid),
    .key_ack(key_ack),
    .key_held(key_held),
    .overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Passive matrix model: a pressed key pulls its row low while its column is strobed.
  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (mask[4*r+c] && !cols[c]) rows[r] = 1'b0;
  end

  task automatic wait_valid(input int maxc, output int n, output bit ok);
    n = 0; ok = 1'b0;
    while (!ok && n < maxc) begin
      @(negedge clk); n++; ok = key_valid;
    end
  endtask

  task automatic align_frame();
    logic [3:0] prev;
    int n;
    bit ok;
    prev = cols; n = 0; ok = 1'b0;
    while (!ok && n < 300) begin
      @(negedge clk); n++;
      ok = (cols == 4'b1110) && (prev == 4'b0111);
      prev = cols;
    end
    total++;
    if (!ok) begin bad++; $display("FAIL align_frame: got timeout want frame start"); end
  endtask

  task automatic ack_pulse();
    key_ack = 1'b1;
    @(negedge clk);
    key_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; mask = '0; key_ack = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (cols !== 4'b1110) begin bad++; $display("FAIL rst_cols: got %b want 1110", cols); end
    total++; if (key_code !== 5'h1F) begin bad++; $display("FAIL rst_code: got %h want 1f", key_code); end
    total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", key_valid); end
    total++; if (key_held !== 1'b0) begin bad++; $display("FAIL rst_held: got %b want 0", key_held); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL rst_overrun: got %b want 0", overrun); end
    reset = 1'b1;
  endtask

  task automatic test_idle();
    logic [3:0] e;
    for (int k = 1; k <= 1000; k++) begin
      @(negedge clk);
      e = 4'b0001 << ((k / 16) % 4);
      total++;
      if (cols !== ~e) begin bad++; $display("FAIL idle_cols k=%0d: got %b want %b", k, cols, ~e); end
      total++;
      if (key_valid !== 1'b0 || key_code !== 5'h1F) begin
        bad++; $display("FAIL idle_out k=%0d: got valid=%b code=%h want 0/1f", k, key_valid, key_code);
      end
    end
  endtask

  task automatic test_press_ack();
    int n; bit ok;
    align_frame();
    mask = 16'h0200;
    wait_valid(400, n, ok);
    total++; if (!ok || n < 256 || n > 320) begin bad++; $display("FAIL press_latency: got %0d ok=%b want 256..320", n, ok); end
    total++; if (key_code !== 5'h09) begin bad++; $display("FAIL press_code: got %h want 09", key_code); end
    total++; if (key_held !== 1'b1) begin bad++; $display("FAIL press_held: got %b want 1", key_held); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL press_overrun: got %b want 0", overrun); end
    ack_pulse();
    total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL ack_clear: got %b want 0", key_valid); end
    mask = '0;
    repeat (6*64) @(negedge clk);
    total++; if (key_held !== 1'b0 || key_code !== 5'h1F) begin bad++; $display("FAIL release: got held=%b code=%h want 0/1f", key_held, key_code); end
    total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL release_noevt: got %b want 0", key_valid); end
  endtask

  task automatic test_bounce();
    int n; bit ok; bit seen;
    seen = 1'b0;
    align_frame();
    for (int f = 0; f < 6; f++) begin
      mask = (f % 2 == 0) ? 16'h0200 : 16'h0000;
      repeat (64) begin @(negedge clk); if (key_valid) seen = 1'b1; end
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL bounce_noevt: got event want none"); end
    mask = 16'h0200;
    wait_valid(400, n, ok);
    total++; if (!ok || n < 256 || n > 320) begin bad++; $display("FAIL bounce_latency: got %0d ok=%b want 256..320", n, ok); end
    total++; if (key_code !== 5'h09) begin bad++; $display("FAIL bounce_code: got %h want 09", key_code); end
    ack_pulse();
    seen = 1'b0;
    repeat (6*64) begin @(negedge clk); if (key_valid) seen = 1'b1; end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL bounce_single: got second event want none"); end
    mask = '0;
    repeat (6*64) @(negedge clk);
  endtask

  task automatic test_overrun();
    int n; bit ok;
    mask = 16'h0008;
    wait_valid(400, n, ok);
    total++; if (!ok || key_code !== 5'h03) begin bad++; $display("FAIL ovr_first: got ok=%b code=%h want 1/03", ok, key_code); end
    mask = 16'h1000;
    n = 0; ok = 1'b0;
    while (!ok && n < 400) begin @(negedge clk); n++; ok = (key_code == 5'h0C); end
    total++; if (!ok) begin bad++; $display("FAIL ovr_code: got %h want 0c", key_code); end
    total++; if (key_valid !== 1'b1) begin bad++; $display("FAIL ovr_valid: got %b want 1", key_valid); end
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_flag: got %b want 1", overrun); end
    mask = '0;
    n = 0; ok = 1'b0;
    while (!ok && n < 400) begin @(negedge clk); n++; ok = (key_held == 1'b0); end
    total++; if (!ok || key_code !== 5'h1F) begin bad++; $display("FAIL ovr_release: got held=%b code=%h want 0/1f", key_held, key_code); end
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
    ack_pulse();
    total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL ovr_ack: got %b want 0", key_valid); end
  endtask

  task automatic test_multi();
    int n; bit ok;
    mask = 16'h0420;
    wait_valid(400, n, ok);
    total++; if (!ok || key_code !== 5'h05) begin bad++; $display("FAIL multi_code: got ok=%b code=%h want 1/05", ok, key_code); end
    total++; if (key_held !== 1'b1) begin bad++; $display("FAIL multi_held: got %b want 1", key_held); end
    ack_pulse();
    mask = '0;
    repeat (6*64) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int n; bit ok;
    mask = 16'h0080;
    wait_valid(400, n, ok);
    total++; if (!ok || key_code !== 5'h07) begin bad++; $display("FAIL mid_setup: got ok=%b code=%h want 1/07", ok, key_code); end
    #2 reset = 1'b0;
    #1;
    total++; if (cols !== 4'b1110) begin bad++; $display("FAIL mid_cols: got %b want 1110", cols); end
    total++; if (key_code !== 5'h1F) begin bad++; $display("FAIL mid_code: got %h want 1f", key_code); end
    total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL mid_valid: got %b want 0", key_valid); end
    total++; if (key_held !== 1'b0) begin bad++; $display("FAIL mid_held: got %b want 0", key_held); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL mid_overrun: got %b want 0", overrun); end
    mask = '0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_repeat();
    int n; bit ok; int c0;
    mask = 16'h0001;
    wait_valid(400, n, ok);
    c0 = cyc;
    total++; if (!ok || key_code !== 5'h00) begin bad++; $display("FAIL rep_first: got ok=%b code=%h want 1/00", ok, key_code); end
    ack_pulse();
    wait_valid(600, n, ok);
`ifdef KEYPAD_REPEAT_EN
    total++; if (!ok || (cyc - c0) != RPT*64) begin bad++; $display("FAIL rep_interval: got %0d ok=%b want %0d", cyc - c0, ok, RPT*64); end
    total++; if (key_code !== 5'h00) begin bad++; $display("FAIL rep_code: got %h want 00", key_code); end
    ack_pulse();
`else
    total++; if (ok !== 1'b0) begin bad++; $display("FAIL rep_none: got event after %0d cycles want none", n); end
`endif
    mask = '0;
    repeat (6*64) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_idle();
    test_press_ack();
    test_bounce();
    test_overrun();
    test_multi();
    test_reset_mid();
    test_repeat();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 active-low key matrix and delivers debounced key events to the user logic. It is the input-side counterpart of the multiplexed seven-segment display driver: it rotates a one-hot active-low strobe across the matrix columns and samples the rows. Each accepted press is handed over through a valid/ack handshake. Key codes use the 5-bit digit format that the display path consumes, so a key can be echoed straight to a display digit.

## Interface
- SCAN_DIV_W, 17: column dwell is 2^SCAN_DIV_W clk cycles (762.939 Hz at 100 MHz).
- DEBOUNCE_FRAMES, 4: number of identical consecutive frames (range 2..15) before a result is accepted.
- REPEAT_FRAMES, 64: auto-repeat interval in frames (used only with KEYPAD_REPEAT_EN).
- clk  in  1  system clock, 100 MHz.
- reset  in  1  asynchronous, active-low reset.
- rows  in  4  matrix row inputs, active low, externally pulled up, asynchronous to clk.
- cols  out  4  column strobes, active low, exactly one low at a time.
- key_code  out  5  accepted key, 5'h00..5'h0F = key index, 5'h1F = none.
- key_valid  out  1  new key event pending; held high until acknowledged.
- key_ack  in  1  consumer acknowledge; sampled high while key_valid is high.
- key_held  out  1  level signal, high while a debounced key is down.
- overrun  out  1  sticky flag; set when an event is lost; cleared only by reset.

## Operation
- rows pass through a 2-flop synchronizer before any use.
- A free-running SCAN_DIV_W-bit divider produces a tick when all its bits are 1.
- On each tick, the synchronized rows are sampled for the active column, then cols rotates left: 1110 -> 1101 -> 1011 -> 0111 -> 1110.
- One frame is 4 ticks.
- Frame result: the lowest index among pressed keys, where index = 4*row + col. A frame with no pressed key gives "none". Ghost or multi-key conditions still resolve to the lowest index.
- Debounce: a candidate register and a frame-match counter track the frame result. A result is accepted as stable when it matches the candidate for DEBOUNCE_FRAMES consecutive frames. Any mismatch loads the new result as candidate and restarts the count at 1.
- State machine, evaluated at frame end:
  - IDLE: stable none; key_held = 0.
  - IDLE -> PRESSED on stable key K: key_code <= K, raise event.
  - PRESSED -> PRESSED(K2) on stable K2 != K: key_code <= K2, raise event.
  - PRESSED -> IDLE on stable none: key_code <= 5'h1F, key_held <= 0, no event.
- Raising an event sets key_valid.
- If key_valid is already high when an event is raised, key_code is updated to the newer key, key_valid stays high, and overrun is set.
- key_valid clears on the cycle after key_ack is sampled high while key_valid is high. key_ack with key_valid low is ignored.
- If an event is raised in the same cycle that key_ack is sampled, the event wins: key_valid stays high and overrun is not set.
- Active-low reset at any time, including mid-frame or mid-handshake, returns all state to its reset values immediately.

## Timing
- Reset values: cols = 4'b1110, key_code = 5'h1F, key_valid = 0, key_held = 0, overrun = 0, divider = 0, state = IDLE, candidate = none, count = 0.
- Row settle: each column is driven for a full dwell before it is sampled.
- Synchronizer latency: 2 cycles; it is absorbed inside the dwell.
- Minimum press-to-key_valid latency: DEBOUNCE_FRAMES frames. That is 4 x 4 x 2^SCAN_DIV_W cycles, plus up to one frame of phase alignment.
- key_valid, key_code and key_held update on the same clk edge, one cycle after the frame-end tick.
- All outputs are registered.

## Configuration
- KEYPAD_REPEAT_EN defined: while in PRESSED with the same key, a repeat event with the same key_code is raised every REPEAT_FRAMES frames after acceptance. Repeat events follow the same handshake and overrun rules as normal events.
- KEYPAD_REPEAT_EN undefined: one event per accepted press. The repeat counter is not built.

## Test plan
All scenarios use SCAN_DIV_W = 4 (16-cycle dwell, 64-cycle frame) and DEBOUNCE_FRAMES = 4.
- Reset then idle for 1000 cycles -> cols steps 1110, 1101, 1011, 0111 every 16 cycles; key_code = 5'h1F, key_valid = 0 throughout.
- Hold key row 2 / col 1 (index 9) low whenever col 1 is strobed -> key_valid rises within 256..320 cycles with key_code = 5'h09 and key_held = 1. Pulse key_ack -> key_valid = 0 on the next cycle.
- Hold key 9 but bounce it every other frame for 6 frames, then hold it steady -> no event during bouncing. Exactly one event follows after 4 steady frames.
- Press key 3, do not ack, then change to key 12 -> key_code = 5'h0C, key_valid stays 1, overrun = 1. Release -> key_code = 5'h1F, key_held = 0.
- Press keys 5 and 10 together -> key_code = 5'h05.
- Assert reset mid-handshake -> all outputs return to their reset values immediately.
- With KEYPAD_REPEAT_EN and REPEAT_FRAMES = 8, hold key 0 and ack each event -> a second event with key_code = 5'h00 arrives 8 frames (512 cycles) after the first.
